// File: rtl/alg_amba_vip_base_delay_pkg.sv
// Shared types, LFSR constants and delay-range helpers for the VIP delay-line schedulers.
package alg_amba_vip_base_delay_pkg;

  localparam int unsigned DLY_W  = 16;
  localparam int unsigned LFSR_W = 32;

  localparam logic [LFSR_W-1:0] LFSR_POLY  = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 32'h0000_0001;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'd0,
    MODE_SWEEP  = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_RSVD   = 2'd3
  } sched_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [DLY_W-1:0] lo;
    logic [DLY_W-1:0] hi;
  } dly_bounds_t;

  // Upper bound never falls below the lower bound.
  function automatic dly_bounds_t eff_bounds(logic [DLY_W-1:0] cmin, logic [DLY_W-1:0] cmax);
    dly_bounds_t b;
    b.lo = cmin;
    b.hi = (cmax > cmin) ? cmax : cmin;
    return b;
  endfunction

  // Folds a raw random word into [lo,hi] with a power-of-two mask and one subtract.
  function automatic logic [DLY_W-1:0] range_map(logic [DLY_W-1:0] rnd, dly_bounds_t b);
    logic [DLY_W-1:0] span;
    logic [DLY_W-1:0] mask;
    logic [DLY_W-1:0] r;
    span = b.hi - b.lo;
    mask = span | (span >> 1);
    mask = mask | (mask >> 2);
    mask = mask | (mask >> 4);
    mask = mask | (mask >> 8);
    r    = rnd & mask;
    if (r > span) r = r - (span + DLY_W'(1));
    return b.lo + r;
  endfunction

endpackage

// File: rtl/alg_amba_vip_base_delayline_sched_if.sv
// Window handshake between the scheduler (master) and one delay-line channel (slave).
interface alg_amba_vip_base_delayline_sched_if #(
  parameter int unsigned FIFO_LOG2 = 6
) ();
  logic                 len_valid;
  logic [15:0]          len_value;
  logic [FIFO_LOG2-1:0] nb_req;
  logic                 full_req;
  logic                 need_len;

  modport master (output len_valid, len_value, nb_req, input full_req, need_len);
  modport slave  (input len_valid, len_value, nb_req, output full_req, need_len);
endinterface

// File: rtl/alg_amba_vip_base_lfsr32.sv
// 32-bit Galois LFSR with seed load (zero seed maps to the reset value) and single-step.
module alg_amba_vip_base_lfsr32
  import alg_amba_vip_base_delay_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      value <= LFSR_RESET;
    end else if (load) begin
      value <= (seed == '0) ? LFSR_RESET : seed;
    end else if (step) begin
      value <= value[0] ? ((value >> 1) ^ LFSR_POLY) : (value >> 1);
    end
  end

endmodule

// File: rtl/alg_amba_vip_base_delayline_sched.sv
// Delay-line channel scheduler: opens one window at a time with a fixed, swept or random delay.
module alg_amba_vip_base_delayline_sched
  import alg_amba_vip_base_delay_pkg::*;
#(
  parameter int unsigned SHIFT_LOG2 = 6,
  parameter int unsigned FIFO_LOG2  = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [1:0]           cfg_mode,
  input  logic [DLY_W-1:0]     cfg_min,
  input  logic [DLY_W-1:0]     cfg_max,
  input  logic [FIFO_LOG2-1:0] cfg_nb_req,
  input  logic [LFSR_W-1:0]    cfg_seed,
  input  logic                 cfg_seed_ld,
  input  logic [15:0]          cfg_timeout,
  alg_amba_vip_base_delayline_sched_if.master ch,
  output logic                 busy,
  output logic [31:0]          win_cnt,
  output logic                 timeout_err
);

  localparam logic [DLY_W-1:0] LEN_SAT = DLY_W'((32'd1 << SHIFT_LOG2) - 32'd1);

  sched_state_e         state, state_nxt;
  logic                 wd_expire_c;
  logic [15:0]          wd_cnt;
  logic [15:0]          to_lat;
  logic [DLY_W-1:0]     ptr;
  logic                 sweep_reload;
  logic [LFSR_W-1:0]    lfsr;
  logic                 len_valid_q;
  logic [DLY_W-1:0]     len_value_q;
  logic [FIFO_LOG2-1:0] nb_req_q;
  dly_bounds_t          bnd_c;
  logic [DLY_W-1:0]     sweep_cur_c;
  logic [DLY_W-1:0]     win_val_c;
  logic [DLY_W-1:0]     win_sat_c;
  logic [FIFO_LOG2-1:0] nb_eff_c;
  logic                 unused_lfsr_hi;

  assign ch.len_valid = len_valid_q;
  assign ch.len_value = len_value_q;
  assign ch.nb_req    = nb_req_q;
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:DLY_W];

  alg_amba_vip_base_lfsr32 u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .load  (cfg_seed_ld),
    .step  (state == ST_ISSUE),
    .seed  (cfg_seed),
    .value (lfsr)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Window sequencing; the watchdog closes a stuck window like need_len would.
  always_comb begin
    state_nxt   = state;
    wd_expire_c = 1'b0;
    if ((state == ST_FILL) || (state == ST_DRAIN)) begin
      wd_expire_c = (to_lat != 16'd0) && (16'(wd_cnt + 16'd1) == to_lat);
    end
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_FILL;
      ST_FILL: begin
        if (ch.need_len || wd_expire_c) state_nxt = enable ? ST_ISSUE : ST_IDLE;
        else if (ch.full_req)           state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ch.need_len || wd_expire_c) state_nxt = enable ? ST_ISSUE : ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Delay value for the window being issued, from the live configuration.
  always_comb begin
    bnd_c       = eff_bounds(cfg_min, cfg_max);
    sweep_cur_c = (sweep_reload || (ptr < bnd_c.lo) || (ptr > bnd_c.hi)) ? bnd_c.lo : ptr;
    win_val_c   = bnd_c.lo;
    case (sched_mode_e'(cfg_mode))
      MODE_SWEEP:  win_val_c = sweep_cur_c;
      MODE_RANDOM: win_val_c = range_map(lfsr[DLY_W-1:0], bnd_c);
      default:     win_val_c = bnd_c.lo;
    endcase
    win_sat_c = (win_val_c > LEN_SAT) ? LEN_SAT : win_val_c;
    nb_eff_c  = (cfg_nb_req == '0) ? FIFO_LOG2'(1) : cfg_nb_req;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_valid_q  <= 1'b0;
      len_value_q  <= '0;
      nb_req_q     <= '0;
      busy         <= 1'b0;
      win_cnt      <= 32'd0;
      timeout_err  <= 1'b0;
      wd_cnt       <= 16'd0;
      to_lat       <= 16'd0;
      ptr          <= cfg_min;
      sweep_reload <= 1'b1;
    end else begin
      len_valid_q <= (state == ST_ISSUE);
      busy        <= (state_nxt != ST_IDLE);
      if (state == ST_IDLE) sweep_reload <= 1'b1;
      if (state == ST_ISSUE) begin
        len_value_q  <= win_sat_c;
        nb_req_q     <= nb_eff_c;
        win_cnt      <= win_cnt + 32'd1;
        wd_cnt       <= 16'd0;
        to_lat       <= cfg_timeout;
        sweep_reload <= 1'b0;
        if (sched_mode_e'(cfg_mode) == MODE_SWEEP) begin
          ptr <= (sweep_cur_c >= bnd_c.hi) ? bnd_c.lo : sweep_cur_c + DLY_W'(1);
        end
      end else if ((state == ST_FILL) || (state == ST_DRAIN)) begin
        wd_cnt <= wd_cnt + 16'd1;
      end
      if (wd_expire_c) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alg_amba_vip_base_delayline_sched.sv
// Directed bench for the delay-line scheduler with a per-cycle behavioural window model.
module tb_alg_amba_vip_base_delayline_sched;

  localparam int unsigned SHIFT_LOG2 = 6;
  localparam int unsigned FIFO_LOG2  = 6;
  localparam int          SAT        = (1 << SHIFT_LOG2) - 1;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 enable;
  logic [1:0]           cfg_mode;
  logic [15:0]          cfg_min, cfg_max;
  logic [FIFO_LOG2-1:0] cfg_nb_req;
  logic [31:0]          cfg_seed;
  logic                 cfg_seed_ld;
  logic [15:0]          cfg_timeout;
  logic                 busy;
  logic [31:0]          win_cnt;
  logic                 timeout_err;

  alg_amba_vip_base_delayline_sched_if #(.FIFO_LOG2(FIFO_LOG2)) ch ();

  alg_amba_vip_base_delayline_sched #(.SHIFT_LOG2(SHIFT_LOG2), .FIFO_LOG2(FIFO_LOG2)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .cfg_mode(cfg_mode), .cfg_min(cfg_min),
    .cfg_max(cfg_max), .cfg_nb_req(cfg_nb_req), .cfg_seed(cfg_seed), .cfg_seed_ld(cfg_seed_ld),
    .cfg_timeout(cfg_timeout), .ch(ch), .busy(busy), .win_cnt(win_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          m_win, m_len, m_nb, m_k;
  logic [31:0] m_lfsr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Uniform-ish fold of the low LFSR half into [lo,hi].
  function automatic int mdl_rand(input logic [31:0] s, input int lo, input int hi);
    int span, mask, raw;
    span = hi - lo;
    mask = 0;
    while (mask < span) mask = mask * 2 + 1;
    raw = int'(s & 32'h0000_FFFF);
    return lo + ((raw & mask) % (span + 1));
  endfunction

  // One clock; the model follows the inputs and every output is compared afterwards.
  task automatic tick();
    int lo, hi, v;
    if (!rstn) begin
      m_win = 0; m_len = 0; m_nb = 0; m_k = 0; m_lfsr = 32'h1;
    end else begin
      if (cfg_seed_ld) m_lfsr = (cfg_seed == 32'd0) ? 32'h1 : cfg_seed;
      if (!enable) m_k = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ch.len_valid === 1'b1) begin
      lo = int'(cfg_min);
      hi = (cfg_max > cfg_min) ? int'(cfg_max) : int'(cfg_min);
      case (cfg_mode)
        2'd1:    begin v = lo + (m_k % (hi - lo + 1)); m_k++; end
        2'd2:    v = mdl_rand(m_lfsr, lo, hi);
        default: v = lo;
      endcase
      m_lfsr = lfsr_next(m_lfsr);
      m_len  = (v > SAT) ? SAT : v;
      m_nb   = (cfg_nb_req == '0) ? 1 : int'(cfg_nb_req);
      m_win++;
    end
    chk("len_value", 32'(ch.len_value), 32'(m_len));
    chk("nb_req", 32'(ch.nb_req), 32'(m_nb));
    chk("win_cnt", win_cnt, 32'(m_win));
  endtask

  task automatic wait_pulse(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (ch.len_valid === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_timeout: no len_valid within %0d cycles (cycle %0d)", max, cyc);
    end
  endtask

  task automatic close_window();
    enable = 1'b0;
    ch.need_len = 1'b1;
    tick();
    ch.need_len = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int p, p2, t, n, bad;
    logic [15:0] rv [20];
    logic [15:0] sv [6];
    logic [15:0] exp2 [6];
    exp2 = '{16'd2, 16'd3, 16'd4, 16'd2, 16'd3, 16'd4};

    rstn = 1'b0; enable = 1'b0; cfg_mode = 2'd0; cfg_min = 16'd0; cfg_max = 16'd0;
    cfg_nb_req = '0; cfg_seed = 32'd0; cfg_seed_ld = 1'b0; cfg_timeout = 16'd0;
    ch.full_req = 1'b0; ch.need_len = 1'b0;
    repeat (2) tick();
    chk("reset_len_valid", 32'(ch.len_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);
    rstn = 1'b1;
    tick();

    // Fixed delay, first-pulse latency and back-to-back window latency.
    cfg_mode = 2'd0; cfg_min = 16'd5; cfg_nb_req = 6'd4;
    enable = 1'b1;
    t = cyc;
    wait_pulse(10, p);
    chk("t1_first_pulse_cycle", 32'(p), 32'(t + 2));
    chk("t1_value", 32'(ch.len_value), 32'd5);
    chk("t1_nb", 32'(ch.nb_req), 32'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    tick(); tick();
    ch.full_req = 1'b1; tick(); ch.full_req = 1'b0; tick();
    ch.need_len = 1'b1; t = cyc; tick(); ch.need_len = 1'b0;
    wait_pulse(10, p);
    chk("t1_b2b_cycle", 32'(p), 32'(t + 2));

    // Enable dropped during FILL: window finishes, no new pulse.
    tick();
    enable = 1'b0;
    tick();
    ch.full_req = 1'b1; tick(); ch.full_req = 1'b0;
    ch.need_len = 1'b1;
    chk("t5_busy_before", 32'(busy), 32'd1);
    tick(); ch.need_len = 1'b0;
    chk("t5_busy_drop", 32'(busy), 32'd0);
    n = 0;
    repeat (6) begin tick(); if (ch.len_valid === 1'b1) n++; end
    chk("t5_no_pulse", 32'(n), 32'd0);

    // full_req and need_len together in FILL.
    enable = 1'b1;
    wait_pulse(10, p);
    tick();
    ch.full_req = 1'b1; ch.need_len = 1'b1; t = cyc;
    tick();
    ch.full_req = 1'b0; ch.need_len = 1'b0;
    wait_pulse(10, p);
    chk("t5_both_cycle", 32'(p), 32'(t + 2));
    close_window();

    // Saturation and zero transfer count.
    cfg_min = 16'd100; cfg_nb_req = 6'd0;
    enable = 1'b1;
    wait_pulse(10, p);
    chk("t4_sat", 32'(ch.len_value), 32'd63);
    chk("t4_nb_min", 32'(ch.nb_req), 32'd1);
    close_window();

    // Sweep over [2,4] from a fresh reset.
    do_reset();
    cfg_mode = 2'd1; cfg_min = 16'd2; cfg_max = 16'd4; cfg_nb_req = 6'd3;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_pulse(10, p);
      sv[i] = ch.len_value;
      if (i < 5) begin ch.need_len = 1'b1; tick(); ch.need_len = 1'b0; end
      else close_window();
    end
    for (int i = 0; i < 6; i++) chk($sformatf("t2_sweep_%0d", i), 32'(sv[i]), 32'(exp2[i]));
    chk("t2_win_cnt", win_cnt, 32'd6);

    // Random over [10,20], then reseed and replay.
    cfg_mode = 2'd2; cfg_min = 16'd10; cfg_max = 16'd20; cfg_nb_req = 6'd2;
    cfg_seed = 32'h0000_ACE1; cfg_seed_ld = 1'b1; tick(); cfg_seed_ld = 1'b0; tick();
    enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_pulse(10, p);
      if (i < 20) rv[i] = ch.len_value;
      if ((ch.len_value < 16'd10) || (ch.len_value > 16'd20)) bad++;
      if (i == 999) close_window();
      else begin ch.need_len = 1'b1; tick(); ch.need_len = 1'b0; end
    end
    chk("t3_range", 32'(bad), 32'd0);
    chk("t3_rand_0", 32'(rv[0]), 32'd11);
    chk("t3_rand_1", 32'(rv[1]), 32'd13);
    chk("t3_rand_2", 32'(rv[2]), 32'd20);
    cfg_seed_ld = 1'b1; tick(); cfg_seed_ld = 1'b0; tick();
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_pulse(10, p);
      chk($sformatf("t3_replay_%0d", i), 32'(ch.len_value), 32'(rv[i]));
      if (i == 19) close_window();
      else begin ch.need_len = 1'b1; tick(); ch.need_len = 1'b0; end
    end

    // Watchdog expiry, follow-on window, then reset mid-FILL.
    do_reset();
    cfg_mode = 2'd0; cfg_min = 16'd3; cfg_nb_req = 6'd1; cfg_timeout = 16'd8;
    enable = 1'b1;
    wait_pulse(10, p);
    while (cyc < p + 7) tick();
    chk("t6_err_not_yet", 32'(timeout_err), 32'd0);
    tick();
    chk("t6_err_set", 32'(timeout_err), 32'd1);
    wait_pulse(5, p2);
    chk("t6_next_pulse", 32'(p2), 32'(p + 9));
    tick(); tick();
    rstn = 1'b0;
    tick();
    chk("t6_rst_len_valid", 32'(ch.len_valid), 32'd0);
    chk("t6_rst_len_value", 32'(ch.len_value), 32'd0);
    chk("t6_rst_nb_req", 32'(ch.nb_req), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_win_cnt", win_cnt, 32'd0);
    chk("t6_rst_timeout_err", 32'(timeout_err), 32'd0);
    enable = 1'b0; cfg_timeout = 16'd0;
    rstn = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
